// File: rtl/dlx_pkg.sv
// Shared DLX definitions: memory opcodes, access sizes and a small decoder.
package dlx_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {BYTE, HALF, WORD} acc_size_e;

  typedef struct packed {
    logic      is_load;
    logic      is_store;
    logic      is_signed;
    acc_size_e size;
  } mem_dec_t;

  // Non-memory opcodes decode with both is_load and is_store clear.
  function automatic mem_dec_t decode_op(input logic [5:0] op);
    mem_dec_t d;
    d = '{is_load: 1'b0, is_store: 1'b0, is_signed: 1'b0, size: WORD};
    case (op)
      OP_LB:   d = '{is_load: 1'b1, is_store: 1'b0, is_signed: 1'b1, size: BYTE};
      OP_LH:   d = '{is_load: 1'b1, is_store: 1'b0, is_signed: 1'b1, size: HALF};
      OP_LW:   d = '{is_load: 1'b1, is_store: 1'b0, is_signed: 1'b0, size: WORD};
      OP_LBU:  d = '{is_load: 1'b1, is_store: 1'b0, is_signed: 1'b0, size: BYTE};
      OP_LHU:  d = '{is_load: 1'b1, is_store: 1'b0, is_signed: 1'b0, size: HALF};
      OP_SB:   d = '{is_load: 1'b0, is_store: 1'b1, is_signed: 1'b0, size: BYTE};
      OP_SH:   d = '{is_load: 1'b0, is_store: 1'b1, is_signed: 1'b0, size: HALF};
      OP_SW:   d = '{is_load: 1'b0, is_store: 1'b1, is_signed: 1'b0, size: WORD};
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage.
interface mem_stage_if;
  import dlx_pkg::*;

  logic [31:0] Result_mem;
  logic [31:0] mem_data_ex;
  logic [5:0]  opcode_mem;
  logic        MemWrite_mem;
  logic        MemtoReg_mem;
  logic        RegWrite_mem;
  logic [4:0]  towrite_mem;
  logic [31:0] fwd_data_mem;
  logic [31:0] wb_data;
  logic [4:0]  towrite_wb;
  logic        RegWrite_wb;
  logic        misalign_wb;

  modport master (
    output Result_mem, mem_data_ex, opcode_mem, MemWrite_mem, MemtoReg_mem, RegWrite_mem,
           towrite_mem,
    input  fwd_data_mem, wb_data, towrite_wb, RegWrite_wb, misalign_wb
  );

  modport slave (
    input  Result_mem, mem_data_ex, opcode_mem, MemWrite_mem, MemtoReg_mem, RegWrite_mem,
           towrite_mem,
    output fwd_data_mem, wb_data, towrite_wb, RegWrite_wb, misalign_wb
  );
endinterface

// File: rtl/dff_ar.sv
// Plain D flip-flop bank with asynchronous active-high reset.
module dff_ar #(
  parameter int unsigned       WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  // Capture every cycle; reset forces RST_VAL immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_q <= RST_VAL;
    else       r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/dmem.sv
// Word-organised data memory with byte-lane write enables and combinational read.
module dmem #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH_WORDS];

  // Lane b covers bits [8b+7:8b]; contents are not reset.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we && i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  assign o_rdata = r_mem[i_idx];
endmodule

// File: rtl/mem_stage.sv
// DLX MEM stage: big-endian load/store lanes, alignment check and the MEM/WB register.
module mem_stage
  import dlx_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 8
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);
  mem_dec_t    w_dec;
  logic        w_is_mem;
  logic [1:0]  w_off;
  logic [AW-1:0] w_idx;
  logic        w_misaligned;
  logic        w_we;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_fwd;
  logic        w_rw_d;
  logic        w_unused;

  assign w_dec    = decode_op(bus.opcode_mem);
  assign w_is_mem = w_dec.is_load | w_dec.is_store;
  assign w_off    = bus.Result_mem[1:0];
  // Upper address bits are dropped, so addresses wrap modulo DEPTH_WORDS.
  assign w_idx    = bus.Result_mem[AW+1:2];
  assign w_unused = ^bus.Result_mem[31:AW+2];

  // Alignment check, only meaningful for loads and stores.
  always_comb begin
    w_misaligned = 1'b0;
    case (w_dec.size)
      HALF:    w_misaligned = w_off[0];
      WORD:    w_misaligned = (w_off != 2'b00);
      default: w_misaligned = 1'b0;
    endcase
    w_misaligned = w_misaligned & w_is_mem;
  end

  // Store lane selection; offset 0 is the most significant byte.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = bus.mem_data_ex;
    case (w_dec.size)
      BYTE: begin
        w_be    = 4'b1000 >> w_off;
        w_wdata = {4{bus.mem_data_ex[7:0]}};
      end
      HALF: begin
        w_be    = w_off[1] ? 4'b0011 : 4'b1100;
        w_wdata = {2{bus.mem_data_ex[15:0]}};
      end
      default: w_be = 4'b1111;
    endcase
  end

  assign w_we = bus.MemWrite_mem & w_dec.is_store & ~w_misaligned & ~reset;

  dmem #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_dmem (
    .i_clk  (clk),
    .i_we   (w_we),
    .i_be   (w_be),
    .i_idx  (w_idx),
    .i_wdata(w_wdata),
    .o_rdata(w_rdata)
  );

  // Load lane extraction with sign or zero extension.
  always_comb begin
    case (w_off)
      2'd0:    w_byte = w_rdata[31:24];
      2'd1:    w_byte = w_rdata[23:16];
      2'd2:    w_byte = w_rdata[15:8];
      default: w_byte = w_rdata[7:0];
    endcase
    w_half = w_off[1] ? w_rdata[15:0] : w_rdata[31:16];
    case (w_dec.size)
      BYTE:    w_load = {{24{w_dec.is_signed & w_byte[7]}}, w_byte};
      HALF:    w_load = {{16{w_dec.is_signed & w_half[15]}}, w_half};
      default: w_load = w_rdata;
    endcase
  end

  assign w_fwd            = bus.MemtoReg_mem ? w_load : bus.Result_mem;
  assign bus.fwd_data_mem = w_fwd;

  // Misaligned loads and writes to r0 never reach the register file.
  assign w_rw_d = bus.RegWrite_mem & ~(w_dec.is_load & w_misaligned) & (bus.towrite_mem != 5'd0);

  dff_ar #(.WIDTH(32)) u_wb_data (
    .i_clk(clk), .i_rst(reset), .i_d(w_fwd), .o_q(bus.wb_data)
  );
  dff_ar #(.WIDTH(5)) u_towrite (
    .i_clk(clk), .i_rst(reset), .i_d(bus.towrite_mem), .o_q(bus.towrite_wb)
  );
  dff_ar #(.WIDTH(1)) u_regwrite (
    .i_clk(clk), .i_rst(reset), .i_d(w_rw_d), .o_q(bus.RegWrite_wb)
  );
  dff_ar #(.WIDTH(1)) u_misalign (
    .i_clk(clk), .i_rst(reset), .i_d(w_misaligned), .o_q(bus.misalign_wb)
  );
endmodule

// File: tb/tb_mem_stage.sv
// Directed vector bench for mem_stage.
module tb_mem_stage;
  import dlx_pkg::*;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        mw;
    logic        m2r;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] exp_wb;
    logic        exp_rw;
    logic        exp_mis;
  } vec_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  vec_t vecs[$];

  mem_stage_if bus ();

  mem_stage #(
    .DEPTH_WORDS(256),
    .AW         (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic mw, input logic m2r, input logic rw, input logic [4:0] rd);
    bus.opcode_mem   = op;
    bus.Result_mem   = addr;
    bus.mem_data_ex  = data;
    bus.MemWrite_mem = mw;
    bus.MemtoReg_mem = m2r;
    bus.RegWrite_mem = rw;
    bus.towrite_mem  = rd;
  endtask

  task automatic chk_wb(input string tag, input logic [31:0] wb, input logic [4:0] rd,
                        input logic rw, input logic mis);
    chk({tag, " wb_data"},     bus.wb_data,            wb);
    chk({tag, " towrite_wb"},  {27'd0, bus.towrite_wb}, {27'd0, rd});
    chk({tag, " RegWrite_wb"}, {31'd0, bus.RegWrite_wb}, {31'd0, rw});
    chk({tag, " misalign_wb"}, {31'd0, bus.misalign_wb}, {31'd0, mis});
  endtask

  task automatic apply(input vec_t v, input int n);
    @(negedge clk);
    drive(v.op, v.addr, v.data, v.mw, v.m2r, v.rw, v.rd);
    #1 chk($sformatf("v%0d fwd_data_mem", n), bus.fwd_data_mem, v.exp_wb);
    @(posedge clk);
    #1 chk_wb($sformatf("v%0d", n), v.exp_wb, v.rd, v.exp_rw, v.exp_mis);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    //                op      addr        data          mw    m2r   rw    rd     exp_wb        rw    mis
    vecs.push_back('{OP_SW,  32'h10,     32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 5'd0,  32'h00000010, 1'b0, 1'b0});
    vecs.push_back('{OP_LW,  32'h10,     32'h0,        1'b0, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 1'b0});
    vecs.push_back('{OP_SB,  32'h11,     32'h00000080, 1'b1, 1'b0, 1'b0, 5'd0,  32'h00000011, 1'b0, 1'b0});
    vecs.push_back('{OP_LW,  32'h10,     32'h0,        1'b0, 1'b1, 1'b1, 5'd6,  32'hDE80BEEF, 1'b1, 1'b0});
    vecs.push_back('{OP_LB,  32'h11,     32'h0,        1'b0, 1'b1, 1'b1, 5'd7,  32'hFFFFFF80, 1'b1, 1'b0});
    vecs.push_back('{OP_LBU, 32'h11,     32'h0,        1'b0, 1'b1, 1'b1, 5'd8,  32'h00000080, 1'b1, 1'b0});
    vecs.push_back('{OP_LH,  32'h12,     32'h0,        1'b0, 1'b1, 1'b1, 5'd9,  32'hFFFFBEEF, 1'b1, 1'b0});
    vecs.push_back('{OP_LHU, 32'h10,     32'h0,        1'b0, 1'b1, 1'b1, 5'd10, 32'h0000DE80, 1'b1, 1'b0});
    vecs.push_back('{OP_LW,  32'h12,     32'h0,        1'b0, 1'b1, 1'b1, 5'd3,  32'hDE80BEEF, 1'b0, 1'b1});
    vecs.push_back('{OP_SH,  32'h13,     32'h00001234, 1'b1, 1'b0, 1'b0, 5'd0,  32'h00000013, 1'b0, 1'b1});
    vecs.push_back('{OP_LW,  32'h10,     32'h0,        1'b0, 1'b1, 1'b1, 5'd4,  32'hDE80BEEF, 1'b1, 1'b0});
    vecs.push_back('{OP_SH,  32'h12,     32'hCAFE1234, 1'b1, 1'b0, 1'b0, 5'd0,  32'h00000012, 1'b0, 1'b0});
    vecs.push_back('{OP_LW,  32'h10,     32'h0,        1'b0, 1'b1, 1'b1, 5'd4,  32'hDE801234, 1'b1, 1'b0});
    vecs.push_back('{OP_SW,  32'h400,    32'h0BADF00D, 1'b1, 1'b0, 1'b0, 5'd0,  32'h00000400, 1'b0, 1'b0});
    vecs.push_back('{OP_LW,  32'h0,      32'h0,        1'b0, 1'b1, 1'b1, 5'd1,  32'h0BADF00D, 1'b1, 1'b0});
    vecs.push_back('{6'h00,  32'h1234,   32'h0,        1'b0, 1'b0, 1'b1, 5'd7,  32'h00001234, 1'b1, 1'b0});
    vecs.push_back('{6'h00,  32'h10,     32'h11111111, 1'b1, 1'b0, 1'b0, 5'd0,  32'h00000010, 1'b0, 1'b0});
    vecs.push_back('{OP_LW,  32'h10,     32'h0,        1'b0, 1'b1, 1'b1, 5'd2,  32'hDE801234, 1'b1, 1'b0});
    vecs.push_back('{OP_LW,  32'h10,     32'h0,        1'b0, 1'b1, 1'b1, 5'd0,  32'hDE801234, 1'b0, 1'b0});
    vecs.push_back('{OP_LB,  32'h10,     32'h0,        1'b0, 1'b1, 1'b1, 5'd11, 32'hFFFFFFDE, 1'b1, 1'b0});
    vecs.push_back('{OP_LH,  32'h11,     32'h0,        1'b0, 1'b1, 1'b1, 5'd12, 32'hFFFFDE80, 1'b0, 1'b1});
    vecs.push_back('{OP_LBU, 32'h12,     32'h0,        1'b0, 1'b1, 1'b1, 5'd13, 32'h00000012, 1'b1, 1'b0});
    vecs.push_back('{OP_LW,  32'h410,    32'h0,        1'b0, 1'b1, 1'b1, 5'd14, 32'hDE801234, 1'b1, 1'b0});

    // Reset state.
    reset = 1'b1;
    drive(6'h00, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b1, 5'd31);
    repeat (2) @(posedge clk);
    #1 chk_wb("reset", 32'h0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset pulsed between edges while RegWrite_wb is high.
    apply('{OP_LW, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 5'd5, 32'hDE801234, 1'b1, 1'b0}, 100);
    #2 reset = 1'b1;
    #1 chk_wb("async reset", 32'h0, 5'd0, 1'b0, 1'b0);
    // A store presented during reset must not land.
    @(negedge clk);
    drive(OP_SW, 32'h10, 32'h55555555, 1'b1, 1'b0, 1'b1, 5'd3);
    @(posedge clk);
    #1 chk_wb("held reset", 32'h0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive(6'h00, 32'h77, 32'h0, 1'b0, 1'b0, 1'b1, 5'd9);
    @(posedge clk);
    #1 chk_wb("first capture", 32'h77, 5'd9, 1'b1, 1'b0);
    apply('{OP_LW, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 5'd6, 32'hDE801234, 1'b1, 1'b0}, 101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
